// File: rtl/resp_circ_buf_if.sv
// Response-side bundle for resp_circ_buf: upstream push port, downstream
// valid/ready drain port and the status outputs.
interface resp_circ_buf_if #(
    parameter int DEPTH = 8,
    parameter int AW    = 36,
    parameter int DW    = 512
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          overwrite;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] data_in;
    logic [3:0]    id_in;
    logic [2:0]    packet_type_in;

    logic          resp_valid;
    logic          resp_ready;
    logic [AW-1:0] resp_addr;
    logic [DW-1:0] resp_data;
    logic [3:0]    resp_id;
    logic [2:0]    resp_type;

    logic [CW-1:0] count;
    logic          full;
    logic          overflow;
    logic [15:0]   drop_cnt;
    logic [CW-1:0] high_water;

    modport master (
        output overwrite, addr_in, data_in, id_in, packet_type_in, resp_ready,
        input  resp_valid, resp_addr, resp_data, resp_id, resp_type,
        input  count, full, overflow, drop_cnt, high_water
    );

    modport slave (
        input  overwrite, addr_in, data_in, id_in, packet_type_in, resp_ready,
        output resp_valid, resp_addr, resp_data, resp_id, resp_type,
        output count, full, overflow, drop_cnt, high_water
    );
endinterface

// File: rtl/resp_circ_buf.sv
// Overwriting response circular buffer with first-word-fall-through drain.
// Define RESP_CIRC_BUF_STATS_EN to build the drop_cnt / high_water counters.
module resp_circ_buf #(
    parameter int DEPTH = 8,
    parameter int AW    = 36,
    parameter int DW    = 512
) (
    input  logic            clk,
    input  logic            rst,
    resp_circ_buf_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [3:0]    id_mem   [DEPTH];
    logic [2:0]    type_mem [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          push, pop, drop;

    // Upstream cannot stall, so a push into a full buffer without a pop evicts the oldest entry.
    always_comb begin
        push       = bus.overwrite;
        pop        = (count_q != '0) && bus.resp_ready;
        drop       = push && !pop && (count_q == FULL_CNT);
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push)
            wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop || drop)
            rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop && !drop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);
        if (drop)
            overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is never cleared; a push coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            addr_mem[wr_ptr_q] <= bus.addr_in;
            data_mem[wr_ptr_q] <= bus.data_in;
            id_mem[wr_ptr_q]   <= bus.id_in;
            type_mem[wr_ptr_q] <= bus.packet_type_in;
        end
    end

    assign bus.resp_valid = (count_q != '0);
    assign bus.resp_addr  = addr_mem[rd_ptr_q];
    assign bus.resp_data  = data_mem[rd_ptr_q];
    assign bus.resp_id    = id_mem[rd_ptr_q];
    assign bus.resp_type  = type_mem[rd_ptr_q];
    assign bus.count      = count_q;
    assign bus.full       = (count_q == FULL_CNT);
    assign bus.overflow   = overflow_q;

`ifdef RESP_CIRC_BUF_STATS_EN
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] high_water_q, high_water_d;

    // Drop counter saturates instead of wrapping so a long-lost count stays visible.
    always_comb begin
        drop_cnt_d   = drop_cnt_q;
        high_water_d = high_water_q;
        if (drop && (drop_cnt_q != 16'hFFFF))
            drop_cnt_d = drop_cnt_q + 16'd1;
        if (count_d > high_water_q)
            high_water_d = count_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt_q   <= '0;
            high_water_q <= '0;
        end else begin
            drop_cnt_q   <= drop_cnt_d;
            high_water_q <= high_water_d;
        end
    end

    assign bus.drop_cnt   = drop_cnt_q;
    assign bus.high_water = high_water_q;
`else
    assign bus.drop_cnt   = '0;
    assign bus.high_water = '0;
`endif
endmodule

// File: tb/tb_resp_circ_buf.sv
// Directed and model-based bench for resp_circ_buf at DEPTH = 8.
// Statistics expectations follow whether RESP_CIRC_BUF_STATS_EN is defined.
module tb_resp_circ_buf;
    localparam int DEPTH = 8;
    localparam int AW    = 36;
    localparam int DW    = 512;

    typedef struct {
        logic        push;
        logic [35:0] addr;
        logic [31:0] data;
        logic [3:0]  id;
        logic [2:0]  typ;
        logic        ready;
        logic        expValid;
        logic [3:0]  expCount;
        logic        expFull;
        logic        expOverflow;
        logic [3:0]  expId;
        logic [2:0]  expType;
        logic [35:0] expAddr;
        logic [31:0] expData;
        logic [15:0] expDrop;
        logic [3:0]  expHigh;
    } vec_t;

    typedef struct {
        logic [35:0]  addr;
        logic [511:0] data;
        logic [3:0]   id;
        logic [2:0]   typ;
    } pkt_t;

    logic clk;
    logic rst;
    int   numChecks;
    int   numFails;

    resp_circ_buf_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    resp_circ_buf #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running 10 ns clock for the whole run
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Statistics outputs read zero when the counters are not built
    function automatic logic [15:0] expDropOf(input logic [15:0] v);
`ifdef RESP_CIRC_BUF_STATS_EN
        return v;
`else
        return (v & 16'h0);
`endif
    endfunction

    function automatic logic [3:0] expHighOf(input logic [3:0] v);
`ifdef RESP_CIRC_BUF_STATS_EN
        return v;
`else
        return (v & 4'h0);
`endif
    endfunction

    function automatic vec_t mkVec(
        input logic push, input logic [35:0] addr, input logic [31:0] data,
        input logic [3:0] id, input logic [2:0] typ, input logic ready,
        input logic expValid, input logic [3:0] expCount, input logic expFull,
        input logic expOverflow, input logic [3:0] expId, input logic [2:0] expType,
        input logic [35:0] expAddr, input logic [31:0] expData,
        input logic [15:0] expDrop, input logic [3:0] expHigh);
        vec_t v;
        v.push = push; v.addr = addr; v.data = data; v.id = id; v.typ = typ;
        v.ready = ready; v.expValid = expValid; v.expCount = expCount;
        v.expFull = expFull; v.expOverflow = expOverflow; v.expId = expId;
        v.expType = expType; v.expAddr = expAddr; v.expData = expData;
        v.expDrop = expDrop; v.expHigh = expHigh;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        numChecks++;
        if (act !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then settle past it
    task automatic applyStimulus(input logic push, input logic [35:0] addr,
                                 input logic [511:0] data, input logic [3:0] id,
                                 input logic [2:0] typ, input logic ready);
        bus.overwrite      = push;
        bus.addr_in        = addr;
        bus.data_in        = data;
        bus.id_in          = id;
        bus.packet_type_in = typ;
        bus.resp_ready     = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b0;
        applyStimulus(1'b0, '0, '0, 4'h0, 3'b000, 1'b0);
        applyStimulus(1'b0, '0, '0, 4'h0, 3'b000, 1'b0);
        rst = 1'b1;
    endtask

    task automatic checkVector(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        checkOutput({tag, "_valid"},    512'(bus.resp_valid), 512'(v.expValid));
        checkOutput({tag, "_count"},    512'(bus.count),      512'(v.expCount));
        checkOutput({tag, "_full"},     512'(bus.full),       512'(v.expFull));
        checkOutput({tag, "_overflow"}, 512'(bus.overflow),   512'(v.expOverflow));
        checkOutput({tag, "_drop"},     512'(bus.drop_cnt),   512'(expDropOf(v.expDrop)));
        checkOutput({tag, "_high"},     512'(bus.high_water), 512'(expHighOf(v.expHigh)));
        if (v.expValid) begin
            checkOutput({tag, "_id"},   512'(bus.resp_id),         512'(v.expId));
            checkOutput({tag, "_type"}, 512'(bus.resp_type),       512'(v.expType));
            checkOutput({tag, "_addr"}, 512'(bus.resp_addr),       512'(v.expAddr));
            checkOutput({tag, "_data"}, 512'(bus.resp_data[31:0]), 512'(v.expData));
        end
    endtask

    // Directed table first, then the multi-cycle corner sequences and the random stream
    initial begin
        vec_t vecs[$];
        pkt_t model[$];
        pkt_t p;
        int   maxCount;
        logic modelOverflow;
        logic doPush, doReady, doPop;

        numChecks = 0;
        numFails  = 0;
        rst = 1'b0;
        bus.overwrite = 1'b0; bus.addr_in = '0; bus.data_in = '0;
        bus.id_in = '0; bus.packet_type_in = '0; bus.resp_ready = 1'b0;

        for (int i = 0; i < 5; i++)
            vecs.push_back(mkVec(0, 36'h0, 32'h0, 4'h0, 3'b000, 0,
                                 0, 4'd0, 0, 0, 4'h0, 3'b000, 36'h0, 32'h0, 16'd0, 4'd0));
        vecs.push_back(mkVec(1, 36'h8, 32'h5, 4'h3, 3'b110, 0,
                             1, 4'd1, 0, 0, 4'h3, 3'b110, 36'h8, 32'h5, 16'd0, 4'd1));
        vecs.push_back(mkVec(0, 36'h0, 32'h0, 4'h0, 3'b000, 1,
                             0, 4'd0, 0, 0, 4'h0, 3'b000, 36'h0, 32'h0, 16'd0, 4'd1));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mkVec(1, 36'(i * 16), 32'(100 + i), 4'(i), 3'b101, 0,
                                 1, 4'(i + 1), (i == 7), 0, 4'h0, 3'b101, 36'h0, 32'd100,
                                 16'd0, 4'(i + 1)));
        vecs.push_back(mkVec(1, 36'(8 * 16), 32'd108, 4'd8, 3'b101, 0,
                             1, 4'd8, 1, 1, 4'd1, 3'b101, 36'h10, 32'd101, 16'd1, 4'd8));
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mkVec(0, 36'h0, 32'h0, 4'h0, 3'b000, 1,
                                 (k < 8), 4'(8 - k), 0, 1, 4'(k + 1), 3'b101,
                                 36'((k + 1) * 16), 32'(100 + k + 1), 16'd1, 4'd8));

        $display("[TB] reset, idle, latency, fill/overflow and drain table");
        doReset();
        checkOutput("reset_valid", 512'(bus.resp_valid), 512'(0));
        checkOutput("reset_count", 512'(bus.count), 512'(0));
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].push, vecs[i].addr, 512'(vecs[i].data), vecs[i].id,
                          vecs[i].typ, vecs[i].ready);
            checkVector(i, vecs[i]);
        end

        $display("[TB] simultaneous push/pop at full");
        doReset();
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, 36'(i), 512'(i), 4'(i), 3'b101, 1'b0);
        checkOutput("pp_full_pre", 512'(bus.full), 512'(1));
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("pp_head%0d", i), 512'(bus.resp_id), 512'(i));
            applyStimulus(1'b1, 36'hA, 512'hA, 4'hA, 3'b101, 1'b1);
            checkOutput($sformatf("pp_count%0d", i), 512'(bus.count), 512'(8));
            checkOutput($sformatf("pp_ovf%0d", i), 512'(bus.overflow), 512'(0));
            checkOutput($sformatf("pp_drop%0d", i), 512'(bus.drop_cnt), 512'(0));
        end
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("pp_drain%0d", i), 512'(bus.resp_id),
                        512'((i < 4) ? (i + 4) : 10));
            applyStimulus(1'b0, '0, '0, 4'h0, 3'b000, 1'b1);
        end
        checkOutput("pp_empty", 512'(bus.resp_valid), 512'(0));

        $display("[TB] reset during traffic");
        doReset();
        for (int i = 0; i < 9; i++)
            applyStimulus(1'b1, 36'(i), 512'(i), 4'(i), 3'b110, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, '0, '0, 4'h0, 3'b000, 1'b1);
        checkOutput("mr_count_pre", 512'(bus.count), 512'(5));
        checkOutput("mr_ovf_pre", 512'(bus.overflow), 512'(1));
        rst = 1'b0;
        applyStimulus(1'b1, 36'hF, 512'hF, 4'hF, 3'b110, 1'b1);
        rst = 1'b1;
        checkOutput("mr_count", 512'(bus.count), 512'(0));
        checkOutput("mr_valid", 512'(bus.resp_valid), 512'(0));
        checkOutput("mr_ovf", 512'(bus.overflow), 512'(0));
        checkOutput("mr_drop", 512'(bus.drop_cnt), 512'(0));
        checkOutput("mr_high", 512'(bus.high_water), 512'(0));
        applyStimulus(1'b1, 36'h123, 512'h456, 4'h6, 3'b101, 1'b0);
        checkOutput("mr_next_count", 512'(bus.count), 512'(1));
        checkOutput("mr_next_id", 512'(bus.resp_id), 512'(6));
        checkOutput("mr_next_addr", 512'(bus.resp_addr), 512'(36'h123));
        applyStimulus(1'b0, '0, '0, 4'h0, 3'b000, 1'b1);
        checkOutput("mr_after_pop", 512'(bus.resp_valid), 512'(0));

        $display("[TB] random streaming against queue model");
        doReset();
        maxCount = 0;
        modelOverflow = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            doPush  = 1'($urandom_range(0, 1));
            doReady = 1'($urandom_range(0, 1));
            p.addr = {4'($urandom), 32'($urandom)};
            p.data = {16{32'($urandom)}};
            p.id   = 4'($urandom);
            p.typ  = 3'($urandom);
            checkOutput("rnd_valid", 512'(bus.resp_valid), 512'(model.size() != 0));
            checkOutput("rnd_count", 512'(bus.count), 512'(model.size()));
            if (model.size() != 0) begin
                checkOutput("rnd_id",   512'(bus.resp_id),   512'(model[0].id));
                checkOutput("rnd_type", 512'(bus.resp_type), 512'(model[0].typ));
                checkOutput("rnd_addr", 512'(bus.resp_addr), 512'(model[0].addr));
                checkOutput("rnd_data", bus.resp_data,       model[0].data);
            end
            doPop = doReady && (model.size() != 0);
            applyStimulus(doPush, p.addr, p.data, p.id, p.typ, doReady);
            if (doPop)
                void'(model.pop_front());
            if (doPush) begin
                if (!doPop && model.size() == DEPTH) begin
                    void'(model.pop_front());
                    modelOverflow = 1'b1;
                end
                model.push_back(p);
            end
            if (model.size() > maxCount)
                maxCount = model.size();
        end
        checkOutput("rnd_overflow", 512'(bus.overflow), 512'(modelOverflow));
        checkOutput("rnd_high", 512'(bus.high_water), 512'(expHighOf(4'(maxCount))));
        checkOutput("rnd_high_bound", 512'(bus.high_water <= 4'd8), 512'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end
endmodule
